// File: rtl/vm1_reqc_if.sv
// vm1_reqc_if: request-capture signal bundle between the priority logic and vm1_reqc
// master: drives request inputs, sp/sp_stb and trap pulses; receives rq_* flags and plir
// slave : the request-capture block (vm1_reqc)
interface vm1_reqc_if;
   logic        irq1_in, irq2_in, irq3_in, virq_n, aclo_in;
   logic        uerr_p, qbto_p, dble_p, iato_p;
   logic [10:0] sp;
   logic        sp_stb;
   logic        rq_irq1, rq_irq2, rq_irq3, rq_virq, rq_aclo, rq_acok;
   logic        rq_uerr, rq_qbto, rq_dble, rq_iato, plir;
   modport master (
      output irq1_in, irq2_in, irq3_in, virq_n, aclo_in, uerr_p, qbto_p, dble_p, iato_p, sp, sp_stb,
      input  rq_irq1, rq_irq2, rq_irq3, rq_virq, rq_aclo, rq_acok, rq_uerr, rq_qbto, rq_dble, rq_iato, plir
   );
   modport slave (
      input  irq1_in, irq2_in, irq3_in, virq_n, aclo_in, uerr_p, qbto_p, dble_p, iato_p, sp, sp_stb,
      output rq_irq1, rq_irq2, rq_irq3, rq_virq, rq_aclo, rq_acok, rq_uerr, rq_qbto, rq_dble, rq_iato, plir
   );
endinterface

// File: rtl/vm1_reqc.sv
// vm1_reqc: interrupt/trap/power-fail request capture with ACOK power-up delay
// Ports: clk, rst (async, active-high); bus (vm1_reqc_if.slave) carrying request inputs,
//        sp/sp_stb rearm code, trap pulses, rq_* flags and plir.
// Parameter ACOK_DELAY (1..255): cycles from reset release / aclo fall to rq_acok.
// Macro VM1_REQC_SYNC_EN: adds 2-flop synchronizers on irq1/irq2/irq3/virq_n/aclo.
module vm1_reqc #(
   parameter int unsigned ACOK_DELAY = 16
) (
   input logic       clk,
   input logic       rst,
   vm1_reqc_if.slave bus
);
   typedef enum logic [1:0] {S_WAIT, S_ARMED, S_IDLE} state_t;
   localparam logic [7:0] LP_LOAD = 8'(ACOK_DELAY - 1);
   // sampled asynchronous inputs, packed {aclo, virq_n, irq3, irq2, irq1}
   logic [4:0] w_in;
`ifdef VM1_REQC_SYNC_EN
   logic [4:0] r_sy1, r_sy2;
   // synchronizers reset to the inactive level (virq_n is active-low)
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_sy1 <= 5'b01000;
         r_sy2 <= 5'b01000;
      end else begin
         r_sy1 <= {bus.aclo_in, bus.virq_n, bus.irq3_in, bus.irq2_in, bus.irq1_in};
         r_sy2 <= r_sy1;
      end
   assign w_in = r_sy2;
`else
   assign w_in = {bus.aclo_in, bus.virq_n, bus.irq3_in, bus.irq2_in, bus.irq1_in};
`endif
   logic       r_arm;
   logic [2:0] r_hist;
   logic [2:0] w_cur, w_rise;
   logic       w_aclo_fall;
   logic       w_rm_irq2, w_rm_irq3, w_rm_aclo, w_rm_uop;
   logic       w_unused;
   logic       r_irq1, r_irq2, r_irq3, r_virq, r_aclo, r_acok, r_plir;
   logic [3:0] r_trap;
   state_t     r_state;
   logic [7:0] r_cnt;
   // edge history {aclo, irq3, irq2}; r_arm suppresses edges on the first clock after
   // reset so the level present at release becomes the reference, not an edge
   assign w_cur       = {w_in[4], w_in[2], w_in[1]};
   assign w_rise      = r_arm ? (w_cur & ~r_hist) : 3'b000;
   assign w_aclo_fall = r_arm & r_hist[2] & ~w_in[4];
   assign w_rm_irq2 = bus.sp_stb &  bus.sp[10] &  bus.sp[8] & ~bus.sp[6];
   assign w_rm_irq3 = bus.sp_stb &  bus.sp[10] & ~bus.sp[8] & ~bus.sp[6];
   assign w_rm_aclo = bus.sp_stb & ~bus.sp[10] & ~bus.sp[8] &  bus.sp[6];
   assign w_rm_uop  = bus.sp_stb & ~bus.sp[10] & ~bus.sp[8] & ~bus.sp[6];
   assign w_unused  = ^{bus.sp[9], bus.sp[7], bus.sp[5], bus.sp[3:0]};
   // request flags: set terms are OR'ed last so a set beats a same-cycle rearm
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_arm  <= 1'b0;
         r_hist <= 3'b000;
         r_irq1 <= 1'b0;
         r_virq <= 1'b0;
         r_irq2 <= 1'b0;
         r_irq3 <= 1'b0;
         r_aclo <= 1'b0;
         r_trap <= 4'b0000;
         r_plir <= 1'b0;
      end else begin
         r_arm  <= 1'b1;
         r_hist <= w_cur;
         r_irq1 <= w_in[0];
         r_virq <= ~w_in[3];
         r_irq2 <= w_rise[0] | (r_irq2 & ~w_rm_irq2);
         r_irq3 <= w_rise[1] | (r_irq3 & ~w_rm_irq3);
         r_aclo <= w_rise[2] | (r_aclo & ~w_rm_aclo);
         r_trap <= {bus.uerr_p, bus.qbto_p, bus.dble_p, bus.iato_p} | (r_trap & {4{~w_rm_uop}});
         r_plir <= bus.sp[4];
      end
   // ACOK sequencer: aclo edges override everything, then normal state progression
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= S_WAIT;
         r_cnt   <= LP_LOAD;
         r_acok  <= 1'b0;
      end else if (w_rise[2]) begin
         r_state <= S_IDLE;
         r_acok  <= 1'b0;
      end else if (w_aclo_fall) begin
         r_state <= S_WAIT;
         r_cnt   <= LP_LOAD;
         r_acok  <= 1'b0;
      end else begin
         case (r_state)
            S_WAIT:
               if (r_cnt == 8'd0) begin
                  r_state <= S_ARMED;
                  r_acok  <= 1'b1;
               end else
                  r_cnt <= r_cnt - 8'd1;
            S_ARMED:
               if (w_rm_aclo) begin
                  r_state <= S_IDLE;
                  r_acok  <= 1'b0;
               end
            default: ;
         endcase
      end
   assign bus.rq_irq1 = r_irq1;
   assign bus.rq_irq2 = r_irq2;
   assign bus.rq_irq3 = r_irq3;
   assign bus.rq_virq = r_virq;
   assign bus.rq_aclo = r_aclo;
   assign bus.rq_acok = r_acok;
   assign {bus.rq_uerr, bus.rq_qbto, bus.rq_dble, bus.rq_iato} = r_trap;
   assign bus.plir = r_plir;
endmodule

// File: tb/tb_vm1_reqc.sv
// tb_vm1_reqc: directed self-checking bench for vm1_reqc (default build, ACOK_DELAY=16)
module tb_vm1_reqc;
   localparam logic [10:0] B_IRQ1 = 11'h400, B_IRQ2 = 11'h200, B_IRQ3 = 11'h100, B_VIRQ = 11'h080;
   localparam logic [10:0] B_ACLO = 11'h040, B_ACOK = 11'h020, B_UERR = 11'h010, B_QBTO = 11'h008;
   localparam logic [10:0] B_DBLE = 11'h004, B_IATO = 11'h002, B_PLIR = 11'h001;
   logic        clk, rst;
   int          checks, failures;
   logic [10:0] w_out;
   vm1_reqc_if u_if ();
   vm1_reqc #(.ACOK_DELAY(16)) dut (.clk(clk), .rst(rst), .bus(u_if));
   assign w_out = {u_if.rq_irq1, u_if.rq_irq2, u_if.rq_irq3, u_if.rq_virq, u_if.rq_aclo, u_if.rq_acok,
                   u_if.rq_uerr, u_if.rq_qbto, u_if.rq_dble, u_if.rq_iato, u_if.plir};
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [10:0] exp);
      checks++;
      assert (w_out === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, w_out, exp);
      end
   endtask
   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      u_if.irq1_in = 0; u_if.irq2_in = 0; u_if.irq3_in = 0; u_if.virq_n = 1; u_if.aclo_in = 0;
      u_if.uerr_p = 0; u_if.qbto_p = 0; u_if.dble_p = 0; u_if.iato_p = 0;
      u_if.sp = 11'o0; u_if.sp_stb = 0;
      step(); step();
      chk("reset", 11'h0);
      rst = 1'b0;
      repeat (15) step();
      chk("acok_pre", 11'h0);
      step();
      chk("acok_rise", B_ACOK);
      u_if.sp = 11'o0100; u_if.sp_stb = 1;
      step();
      chk("acok_rearm", 11'h0);
      u_if.sp = 11'o0; u_if.sp_stb = 0;
      step();
      chk("acok_idle", 11'h0);
      u_if.sp = 11'o0020;
      step();
      chk("plir", B_PLIR);
      u_if.sp = 11'o0; u_if.irq1_in = 1; u_if.virq_n = 0;
      step();
      chk("level_on", B_IRQ1 | B_VIRQ);
      u_if.irq1_in = 0; u_if.virq_n = 1;
      step();
      chk("level_off", 11'h0);
      u_if.irq2_in = 1;
      step();
      chk("irq2_set", B_IRQ2);
      u_if.sp = 11'o2400;
      step();
      chk("irq2_nostb", B_IRQ2);
      u_if.sp = 11'o2000; u_if.sp_stb = 1;
      step();
      chk("irq2_wrong_rearm", B_IRQ2);
      u_if.sp = 11'o2400;
      step();
      chk("irq2_rearm", 11'h0);
      u_if.sp = 11'o0; u_if.sp_stb = 0;
      step(); step();
      chk("irq2_hold_high", 11'h0);
      u_if.irq2_in = 0; u_if.irq3_in = 1; u_if.sp = 11'o2000; u_if.sp_stb = 1;
      step();
      chk("irq3_set_wins", B_IRQ3);
      u_if.sp_stb = 0;
      step();
      chk("irq3_held", B_IRQ3);
      u_if.sp_stb = 1;
      step();
      chk("irq3_rearm", 11'h0);
      u_if.sp = 11'o0; u_if.sp_stb = 0; u_if.irq3_in = 0;
      u_if.qbto_p = 1; u_if.uerr_p = 1;
      step();
      chk("trap_set", B_UERR | B_QBTO);
      u_if.qbto_p = 0; u_if.uerr_p = 0;
      step();
      chk("trap_nostb", B_UERR | B_QBTO);
      u_if.dble_p = 1; u_if.iato_p = 1;
      step();
      chk("trap_all", B_UERR | B_QBTO | B_DBLE | B_IATO);
      u_if.dble_p = 0; u_if.iato_p = 0; u_if.sp_stb = 1;
      step();
      chk("trap_clear", 11'h0);
      u_if.uerr_p = 1;
      step();
      chk("trap_set_wins", B_UERR);
      u_if.uerr_p = 0;
      step();
      chk("trap_clear2", 11'h0);
      u_if.sp_stb = 0;
      u_if.aclo_in = 1;
      step();
      chk("aclo_set", B_ACLO);
      repeat (4) step();
      u_if.aclo_in = 0;
      step();
      chk("aclo_fall", B_ACLO);
      repeat (7) step();
      u_if.aclo_in = 1;
      step();
      chk("aclo_reraise", B_ACLO);
      repeat (10) step();
      chk("aclo_abort", B_ACLO);
      u_if.aclo_in = 0;
      repeat (16) step();
      chk("acok_pre2", B_ACLO);
      step();
      chk("acok_rise2", B_ACLO | B_ACOK);
      u_if.sp = 11'o0100; u_if.sp_stb = 1;
      step();
      chk("aclo_rearm", 11'h0);
      u_if.aclo_in = 1;
      step();
      chk("aclo_set_wins", B_ACLO);
      u_if.aclo_in = 0; u_if.sp_stb = 0;
      step();
      chk("aclo_fall2", B_ACLO);
      u_if.sp_stb = 1;
      step();
      chk("aclo_clear_wait", 11'h0);
      u_if.sp = 11'o0; u_if.sp_stb = 0;
      u_if.irq2_in = 1;
      step();
      chk("irq2_pre_rst", B_IRQ2);
      rst = 1'b1;
      #1;
      chk("rst_async", 11'h0);
      step();
      rst = 1'b0;
      repeat (15) step();
      chk("post_rst_pre", 11'h0);
      step();
      chk("post_rst_acok", B_ACOK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
